// File: rtl/ysyx_25060170_fetch_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_25060170_fetch_ctrl_pkg
// Brief    : Shared widths, reset PC, fetch FSM encoding and PC step.
// Revision : 1.0 - initial release
// ============================================================================
package ysyx_25060170_fetch_ctrl_pkg;

    localparam int          c_pc_w      = 32;
    localparam int          c_inst_w    = 32;
    localparam logic [31:0] c_reset_pc  = 32'h8000_0000;
    localparam int          c_inst_step = 4;

    typedef logic [1:0] state_t;

    localparam state_t c_st_boot = 2'd0;
    localparam state_t c_st_req  = 2'd1;
    localparam state_t c_st_wait = 2'd2;
    localparam state_t c_st_hold = 2'd3;

endpackage
`default_nettype wire

// File: rtl/ysyx_25060170_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_25060170_fetch_ctrl
// Brief    : Owns the fetch PC, issues one imem read at a time and buffers
//            the returned instruction for the fetch stage.
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_25060170_fetch_ctrl
    import ysyx_25060170_fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = c_reset_pc,
    parameter int          PC_W     = c_pc_w,
    parameter int          INST_W   = c_inst_w
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              redirect,
    input  logic [PC_W-1:0]   redirect_pc,
    input  logic              core_ready,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [PC_W-1:0]   mem_req_addr,
    input  logic              mem_rsp_valid,
    input  logic [INST_W-1:0] mem_rsp_data,
    input  logic              mem_rsp_err,
    output logic [INST_W-1:0] inst_o,
    output logic [PC_W-1:0]   pc_o,
    output logic              fetch_valid,
    output logic              fetch_err
);

    state_t            r_state;
    logic [PC_W-1:0]   r_pc;
    logic              r_drop;
    logic              r_pend;
    logic [PC_W-1:0]   r_pend_pc;
    logic [INST_W-1:0] r_inst;
    logic [PC_W-1:0]   r_pc_out;
    logic              r_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= c_st_boot;
            r_pc      <= RESET_PC[PC_W-1:0];
            r_drop    <= 1'b0;
            r_pend    <= 1'b0;
            r_pend_pc <= '0;
            r_inst    <= '0;
            r_pc_out  <= '0;
            r_err     <= 1'b0;
        end else begin
            case (r_state)
                c_st_boot: begin
                    if (redirect) r_pc <= redirect_pc;
                    r_state <= c_st_req;
                end
                c_st_req: begin
                    if (mem_req_ready) begin
                        r_state <= c_st_wait;
                        // The accepted read targets the old PC, so its data is wrong-path.
                        if (redirect || r_pend) begin
                            r_drop <= 1'b1;
                            r_pc   <= redirect ? redirect_pc : r_pend_pc;
                            r_pend <= 1'b0;
                        end
                    end else if (redirect) begin
                        // Address must stay stable until accepted; defer the target.
                        r_pend    <= 1'b1;
                        r_pend_pc <= redirect_pc;
                    end
                end
                c_st_wait: begin
                    if (mem_rsp_valid) begin
                        if (r_drop || redirect) begin
                            r_drop  <= 1'b0;
                            if (redirect) r_pc <= redirect_pc;
                            r_state <= c_st_req;
                        end else begin
                            r_inst   <= mem_rsp_data;
                            r_pc_out <= r_pc;
                            r_err    <= mem_rsp_err;
                            r_state  <= c_st_hold;
                        end
                    end else if (redirect) begin
                        r_drop <= 1'b1;
                        r_pc   <= redirect_pc;
                    end
                end
                c_st_hold: begin
                    if (redirect) begin
                        r_pc    <= redirect_pc;
                        r_state <= c_st_req;
                    end else if (core_ready) begin
                        r_pc    <= r_pc + PC_W'(c_inst_step);
                        r_state <= c_st_req;
                    end
                end
                default: r_state <= c_st_boot;
            endcase
        end
    end

    assign mem_req_valid = (r_state == c_st_req);
    assign mem_req_addr  = r_pc;
    assign fetch_valid   = (r_state == c_st_hold);
    assign inst_o        = r_inst;
    assign pc_o          = r_pc_out;
    assign fetch_err     = r_err;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_25060170_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ysyx_25060170_fetch_ctrl
// Brief    : Directed scoreboard bench for the fetch controller.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ysyx_25060170_fetch_ctrl;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        err;
    } fetch_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        core_ready = 1'b0;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b0;
    logic [31:0] mem_req_addr;
    logic        mem_rsp_valid = 1'b0;
    logic [31:0] mem_rsp_data = '0;
    logic        mem_rsp_err = 1'b0;
    logic [31:0] inst_o;
    logic [31:0] pc_o;
    logic        fetch_valid;
    logic        fetch_err;

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] exp_addr_q[$];
    fetch_t      exp_fetch_q[$];
    bit          done = 1'b0;

    ysyx_25060170_fetch_ctrl #(
        .RESET_PC (32'h8000_0000),
        .PC_W     (32),
        .INST_W   (32)
    ) u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc),
        .core_ready    (core_ready),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_addr  (mem_req_addr),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_data  (mem_rsp_data),
        .mem_rsp_err   (mem_rsp_err),
        .inst_o        (inst_o),
        .pc_o          (pc_o),
        .fetch_valid   (fetch_valid),
        .fetch_err     (fetch_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents a request or a new instruction.
    int  outstanding = 0;
    bit  prev_fv = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            outstanding = 0;
            prev_fv = 1'b0;
        end else begin
            if (mem_req_valid && mem_req_ready) begin
                chk("req_while_outstanding", 32'(outstanding), 32'd0);
                if (exp_addr_q.size() == 0) chk("unexpected_req", mem_req_addr, 32'hxxxx_xxxx);
                else chk("req_addr", mem_req_addr, exp_addr_q.pop_front());
                outstanding++;
            end
            if (mem_rsp_valid) begin
                assert (outstanding > 0) else $error("response without request");
                outstanding--;
            end
            if (fetch_valid && !prev_fv) begin
                if (exp_fetch_q.size() == 0) begin
                    chk("unexpected_fetch", pc_o, 32'hxxxx_xxxx);
                end else begin
                    fetch_t e;
                    e = exp_fetch_q.pop_front();
                    chk("fetch_pc", pc_o, e.pc);
                    chk("fetch_inst", inst_o, e.inst);
                    chk("fetch_err", {31'd0, fetch_err}, {31'd0, e.err});
                end
            end
            prev_fv = fetch_valid;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req();
        int n = 0;
        while (!mem_req_valid && n < 20) begin
            tick();
            n++;
        end
        chk("req_timeout", {31'd0, mem_req_valid}, 32'd1);
    endtask

    task automatic accept();
        wait_req();
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
    endtask

    task automatic respond(input logic [31:0] data, input logic err);
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = data;
        mem_rsp_err   = err;
        tick();
        mem_rsp_valid = 1'b0;
        mem_rsp_err   = 1'b0;
    endtask

    task automatic fetch(input logic [31:0] addr, input logic [31:0] data, input logic err);
        exp_addr_q.push_back(addr);
        exp_fetch_q.push_back('{pc: addr, inst: data, err: err});
        accept();
        respond(data, err);
    endtask

    task automatic consume();
        core_ready = 1'b1;
        tick();
        core_ready = 1'b0;
    endtask

    task automatic hold_redirect(input logic [31:0] target, input logic rdy);
        redirect = 1'b1;
        redirect_pc = target;
        core_ready = rdy;
        tick();
        redirect = 1'b0;
        core_ready = 1'b0;
    endtask

    task automatic check_reset_outputs();
        chk("rst_req_valid", {31'd0, mem_req_valid}, 32'd0);
        chk("rst_fetch_valid", {31'd0, fetch_valid}, 32'd0);
        chk("rst_fetch_err", {31'd0, fetch_err}, 32'd0);
        chk("rst_inst", inst_o, 32'd0);
        chk("rst_pc", pc_o, 32'd0);
        chk("rst_addr", mem_req_addr, 32'h8000_0000);
    endtask

    initial begin
        logic [31:0] held_inst;
        logic [31:0] held_pc;
        repeat (3) tick();
        check_reset_outputs();
        rst_n = 1'b1;

        // Basic fetch; request appears one cycle after the boot bubble.
        chk("boot_bubble", {31'd0, mem_req_valid}, 32'd0);
        tick();
        chk("req_at_cycle1", {31'd0, mem_req_valid}, 32'd1);
        fetch(32'h8000_0000, 32'h0000_0413, 1'b0);
        chk("valid_cycle3", {31'd0, fetch_valid}, 32'd1);

        // Stall in HOLD.
        held_inst = inst_o;
        held_pc = pc_o;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_valid", {31'd0, fetch_valid}, 32'd1);
            chk("stall_inst", inst_o, 32'h0000_0413);
            chk("stall_pc", pc_o, 32'h8000_0000);
            chk("stall_no_req", {31'd0, mem_req_valid}, 32'd0);
        end
        consume();
        fetch(32'h8000_0004, 32'h0010_0093, 1'b0);
        consume();

        // Redirect while waiting; the late response is wrong-path.
        exp_addr_q.push_back(32'h8000_0008);
        accept();
        redirect = 1'b1;
        redirect_pc = 32'h8000_0100;
        tick();
        redirect = 1'b0;
        tick();
        respond(32'hBAD0_0001, 1'b0);
        chk("discard_no_valid", {31'd0, fetch_valid}, 32'd0);
        fetch(32'h8000_0100, 32'h0020_0113, 1'b0);
        consume();

        // Redirects while the request is stalled; address must not move.
        wait_req();
        redirect = 1'b1;
        redirect_pc = 32'h8000_0200;
        tick();
        redirect = 1'b0;
        chk("pend_addr0", mem_req_addr, 32'h8000_0104);
        tick();
        chk("pend_addr1", mem_req_addr, 32'h8000_0104);
        redirect = 1'b1;
        redirect_pc = 32'h8000_0300;
        tick();
        redirect = 1'b0;
        chk("pend_addr2", mem_req_addr, 32'h8000_0104);
        exp_addr_q.push_back(32'h8000_0104);
        accept();
        respond(32'hBAD0_0002, 1'b0);
        chk("pend_discard", {31'd0, fetch_valid}, 32'd0);
        fetch(32'h8000_0300, 32'h0030_0193, 1'b0);

        // Redirect beats core_ready in HOLD.
        hold_redirect(32'h8000_0040, 1'b1);
        fetch(32'h8000_0040, 32'hDEAD_BEEF, 1'b1);
        chk("err_flag", {31'd0, fetch_err}, 32'd1);

        // PC wrap.
        hold_redirect(32'hFFFF_FFFC, 1'b0);
        fetch(32'hFFFF_FFFC, 32'h0000_0013, 1'b0);
        consume();
        fetch(32'h0000_0000, 32'h0040_0213, 1'b0);
        consume();

        // Reset in the middle of an outstanding read.
        exp_addr_q.push_back(32'h0000_0004);
        accept();
        rst_n = 1'b0;
        #2;
        check_reset_outputs();
        tick();
        rst_n = 1'b1;
        tick();
        fetch(32'h8000_0000, 32'h0000_1234, 1'b0);
        consume();
        repeat (2) tick();

        chk("addr_q_empty", 32'(exp_addr_q.size()), 32'd0);
        chk("fetch_q_empty", 32'(exp_fetch_q.size()), 32'd0);
        done = 1'b1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #20000;
        if (!done) begin
            $display("FAIL global_timeout: got running expected finished");
            $fatal(1);
        end
    end

endmodule
`default_nettype wire

// File: doc/ysyx_25060170_fetch_ctrl.md
Name: ysyx_25060170_fetch_ctrl

Overview:
Upstream neighbour of the instruction-fetch stage. It owns the architectural fetch PC, issues one instruction-memory read at a time over a valid/ready request channel, and buffers the returned instruction with its PC. It presents the instruction to the fetch stage and advances on that stage's core_ready. Redirects come from the fetch stage's pc_next when any ID/EX/LS jump is asserted; wrong-path responses that are still in flight are discarded.

Parameters:
RESET_PC, 32'h8000_0000, first fetch address after reset
PC_W, 32, PC/address width (matches shared PC macro)
INST_W, 32, instruction width (matches shared INST macro)

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous, active-low reset
redirect  in  1  any of id/ie/ls jump asserted this cycle
redirect_pc  in  PC_W  target PC; valid only when redirect=1
core_ready  in  1  fetch stage consumed the presented instruction
mem_req_valid  out  1  read request valid
mem_req_ready  in  1  memory accepts request
mem_req_addr  out  PC_W  request address
mem_rsp_valid  in  1  read data valid (one response per accepted request, in order)
mem_rsp_data  in  INST_W  instruction word
mem_rsp_err  in  1  access fault on this response
inst_o  out  INST_W  buffered instruction to fetch stage
pc_o  out  PC_W  PC of inst_o
fetch_valid  out  1  inst_o/pc_o hold a valid instruction
fetch_err  out  1  inst_o came from a faulting response; qualified by fetch_valid

Behaviour:
- Reset (async assert, sync release): state=BOOT, pc_q=RESET_PC, drop=0, pend=0, pend_pc=0. Outputs: mem_req_valid=0, fetch_valid=0, fetch_err=0, inst_o=0, pc_o=0, mem_req_addr=RESET_PC.
- FSM states: BOOT, REQ, WAIT, HOLD.
- BOOT: one-cycle bubble, then REQ unconditionally. A redirect in BOOT loads pc_q.
- REQ: mem_req_valid=1, mem_req_addr=pc_q. mem_req_addr is held stable while valid and not ready.
  - Redirect without acceptance: latch pend=1, pend_pc=redirect_pc. A later redirect overwrites pend_pc (latest wins).
  - On acceptance (mem_req_ready=1): go to WAIT. If redirect or pend is set: drop=1, pc_q<=redirect ? redirect_pc : pend_pc, pend<=0.
- WAIT: mem_req_valid=0.
  - Redirect with no response: drop<=1, pc_q<=redirect_pc.
  - mem_rsp_valid with drop=1, or with a redirect in the same cycle: discard the response, drop<=0, go to REQ. pc_q takes redirect_pc if redirect is asserted, otherwise keeps its value.
  - mem_rsp_valid, clean: inst_o<=mem_rsp_data, pc_o<=pc_q, fetch_err<=mem_rsp_err, go to HOLD.
- HOLD: fetch_valid=1.
  - Redirect (priority over core_ready): fetch_valid drops next cycle, pc_q<=redirect_pc, go to REQ.
  - Else core_ready: pc_q<=pc_q+4 (modulo 2^PC_W, wraps silently), go to REQ.
  - Else stall: hold inst_o, pc_o and fetch_err stable.
- Latency: with ready=1 and a response one cycle later, REQ at cycle 0, WAIT at cycle 1, fetch_valid=1 at cycle 2. Best-case throughput is one instruction per 3 cycles.
- A mem_rsp_valid outside WAIT is a protocol violation. It is ignored, with no state change, and the bench asserts on it.
- No new request is issued while a response is outstanding, so at most one read is in flight.
- Reset asserted mid-transaction returns the block to the reset state immediately. The memory model must also be reset; a stale response after release lands in BOOT/REQ and is ignored.
- inst_o/pc_o change only on the WAIT->HOLD transition; values outside HOLD are don't-care.

Decomposition:
- Shared define file: PC/INST width macros (already present), RESET_PC value, FSM state encoding (2-bit localparams), instruction-step constant 4.
- No sub-module is needed. The instruction/PC/err output buffer is inline registers; a separate holding-register module would add ports for no reuse.

Test Plan:
- Reset release, mem_req_ready=1, response next cycle with data 32'h0000_0413: mem_req_addr=0x8000_0000 at cycle 1; fetch_valid=1 at cycle 3 with pc_o=0x8000_0000 and inst_o=0x0000_0413; after core_ready the next request uses addr 0x8000_0004.
- Stall: hold core_ready=0 for 5 cycles in HOLD -> fetch_valid, inst_o and pc_o stay stable; no mem_req_valid is issued.
- Redirect in WAIT to 0x8000_0100, response 2 cycles later -> response is discarded, fetch_valid stays 0, next request addr=0x8000_0100.
- Redirect in REQ with mem_req_ready=0 for 3 cycles to 0x8000_0200, then 0x8000_0300 -> addr stays at the old pc while pending; after acceptance the response is dropped; next request addr=0x8000_0300.
- Redirect and core_ready together in HOLD, target 0x8000_0040 -> next addr=0x8000_0040, not pc+4.
- mem_rsp_err=1 response -> fetch_valid=1 with fetch_err=1. PC 0xFFFF_FFFC with core_ready -> next request addr wraps to 0x0000_0000.
